// File: rtl/mcp3008_spi_responder.sv
// MCP3008-style SPI responder: decodes start/SGL/D2..D0 on MOSI and returns a 10-bit
// sample from a fabric-loaded channel table on MISO, null bit first, MSB first.
//
// state      | meaning
// IDLE       | after reset; wait for cs_n high so a frame already in progress is ignored
// ARMED      | cs_n high, waiting for its falling edge
// WAIT_START | selected, skipping leading zero bits until the start bit
// CMD        | shifting SGL, D2, D1, D0
// SAMPLE     | waiting for the sample clock rise, then the null bit on its fall
// DATA       | shifting the sample out on SCLK falls
// DONE       | sample complete; MISO held at 0 until cs_n rises
module mcp3008_spi_responder #(
  parameter int DATA_WIDTH   = 10,
  parameter int NUM_CHANNELS = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_cs_n,
  input  logic                  spi_clk,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  input  logic                  axiiv,
  input  logic [2:0]            axiic,
  input  logic [DATA_WIDTH-1:0] axiid,
  output logic                  conv_valid,
  output logic [2:0]            conv_channel,
  output logic                  conv_single,
  output logic                  frame_abort,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, ARMED, WAIT_START, CMD, SAMPLE, DATA, DONE} state_t;

  state_t state_q, state_n;

  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic                   cs_prev_q, sclk_prev_q;
  logic                   cs_n_s, sclk_s, mosi_s;
  logic                   cs_rise, cs_fall, sclk_rise, sclk_fall;

  logic [DATA_WIDTH-1:0]  tbl [NUM_CHANNELS];

  logic [CNT_W-1:0]       cnt_q, cnt_n;
  logic [2:0]             cmd_q, cmd_n;
  logic [DATA_WIDTH-1:0]  shift_q, shift_n;
  logic                   miso_q, miso_n;
  logic                   busy_q, busy_n;
  logic                   conv_valid_q, conv_valid_n;
  logic [2:0]             conv_ch_q, conv_ch_n;
  logic                   conv_sgl_q, conv_sgl_n;
  logic                   abort_q, abort_n;

  // cs_n chain resets low so a frame already selected at reset release is never armed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_sync_q   <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      cs_prev_q   <= cs_n_s;
      sclk_prev_q <= sclk_s;
    end
  end

  assign cs_n_s    = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_rise   = cs_n_s & ~cs_prev_q;
  assign cs_fall   = ~cs_n_s & cs_prev_q;
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHANNELS; i++) tbl[i] <= '0;
    end else if (axiiv) begin
      tbl[axiic] <= axiid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cmd_q        <= '0;
      shift_q      <= '0;
      miso_q       <= 1'b0;
      busy_q       <= 1'b0;
      conv_valid_q <= 1'b0;
      conv_ch_q    <= '0;
      conv_sgl_q   <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_n;
      cnt_q        <= cnt_n;
      cmd_q        <= cmd_n;
      shift_q      <= shift_n;
      miso_q       <= miso_n;
      busy_q       <= busy_n;
      conv_valid_q <= conv_valid_n;
      conv_ch_q    <= conv_ch_n;
      conv_sgl_q   <= conv_sgl_n;
      abort_q      <= abort_n;
    end
  end

  always_comb begin
    state_n      = state_q;
    cnt_n        = cnt_q;
    cmd_n        = cmd_q;
    shift_n      = shift_q;
    miso_n       = miso_q;
    busy_n       = busy_q;
    conv_valid_n = 1'b0;
    conv_ch_n    = conv_ch_q;
    conv_sgl_n   = conv_sgl_q;
    abort_n      = 1'b0;
    unique case (state_q)
      IDLE: if (cs_n_s) state_n = ARMED;
      ARMED: if (cs_fall) begin
        state_n = WAIT_START;
        cnt_n   = '0;
      end
      WAIT_START: begin
        if (cs_rise) begin
          state_n = ARMED;
        end else if (sclk_rise && mosi_s) begin
          busy_n  = 1'b1;
          cnt_n   = '0;
          state_n = CMD;
        end
      end
      CMD, SAMPLE, DATA: begin
        if (cs_rise) begin
          state_n = ARMED;
          abort_n = 1'b1;
          busy_n  = 1'b0;
          shift_n = '0;
          miso_n  = 1'b0;
        end else if (state_q == CMD) begin
          if (sclk_rise) begin
            if (cnt_q == CNT_W'(3)) begin
              // table read sees the registered value, so a same-cycle write is not captured
              shift_n      = tbl[{cmd_q[1:0], mosi_s}];
              conv_valid_n = 1'b1;
              conv_ch_n    = {cmd_q[1:0], mosi_s};
              conv_sgl_n   = cmd_q[2];
              cnt_n        = '0;
              state_n      = SAMPLE;
            end else begin
              cmd_n = {cmd_q[1:0], mosi_s};
              cnt_n = cnt_q + CNT_W'(1);
            end
          end
        end else if (state_q == SAMPLE) begin
          if (sclk_rise) begin
            cnt_n = CNT_W'(1);
          end else if (sclk_fall && cnt_q == CNT_W'(1)) begin
            miso_n  = 1'b0;
            cnt_n   = '0;
            state_n = DATA;
          end
        end else if (sclk_fall) begin
          miso_n  = shift_q[DATA_WIDTH-1];
          shift_n = {shift_q[DATA_WIDTH-2:0], 1'b0};
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) state_n = DONE;
          else cnt_n = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (cs_rise) begin
          state_n = ARMED;
          busy_n  = 1'b0;
          miso_n  = 1'b0;
        end else if (sclk_fall) begin
          miso_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign spi_miso     = miso_q;
  assign spi_miso_oe  = ~cs_n_s & (state_q != IDLE);
  assign conv_valid   = conv_valid_q;
  assign conv_channel = conv_ch_q;
  assign conv_single  = conv_sgl_q;
  assign frame_abort  = abort_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_mcp3008_spi_responder.sv
// Directed bench for mcp3008_spi_responder: drives SPI frames with a slow SCLK and
// checks returned samples, command decode, abort and reset behaviour against fixed values.
module tb_mcp3008_spi_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spi_cs_n, spi_clk, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic       axiiv;
  logic [2:0] axiic;
  logic [9:0] axiid;
  logic       conv_valid, conv_single, frame_abort, busy;
  logic [2:0] conv_channel;

  int n_checks = 0;
  int n_fails  = 0;
  int conv_pulses  = 0;
  int abort_pulses = 0;

  always #5 clk = ~clk;

  mcp3008_spi_responder dut (
    .clk(clk), .rst_n(rst_n),
    .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .axiiv(axiiv), .axiic(axiic), .axiid(axiid),
    .conv_valid(conv_valid), .conv_channel(conv_channel), .conv_single(conv_single),
    .frame_abort(frame_abort), .busy(busy)
  );

  always @(negedge clk) begin
    if (conv_valid === 1'b1) conv_pulses++;
    if (frame_abort === 1'b1) abort_pulses++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tbl_write(input logic [2:0] ch, input logic [9:0] d);
    @(negedge clk);
    axiiv = 1'b1; axiic = ch; axiid = d;
    @(negedge clk);
    axiiv = 1'b0;
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_high();
    spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // One SCLK: 5 clk setup, 5 clk high, 5 clk low, MISO sampled at end of low phase.
  // With wr set, a table write lands on the clk edge where the rise is acted on.
  task automatic sclk_cycle(input logic mosi_bit, input logic wr, input logic [2:0] wch,
                            input logic [9:0] wdat, output logic miso_s);
    spi_mosi = mosi_bit;
    repeat (5) @(negedge clk);
    spi_clk = 1'b1;
    if (wr) begin
      repeat (2) @(negedge clk);
      axiiv = 1'b1; axiic = wch; axiid = wdat;
      @(negedge clk);
      axiiv = 1'b0;
      repeat (2) @(negedge clk);
    end else begin
      repeat (5) @(negedge clk);
    end
    spi_clk = 1'b0;
    repeat (5) @(negedge clk);
    miso_s = spi_miso;
  endtask

  task automatic run_frame(input int lead, input int nclk, input logic sgl, input logic [2:0] ch,
                           input logic wr, input logic [2:0] wch, input logic [9:0] wdat,
                           output logic [9:0] data, output logic null_bit, output int tail_ones);
    data = '0; null_bit = 1'b0; tail_ones = 0;
    for (int j = 0; j < lead + nclk; j++) begin
      int k;
      logic b, m;
      k = j - lead;
      b = 1'b0;
      if (k == 0) b = 1'b1;
      else if (k == 1) b = sgl;
      else if (k >= 2 && k <= 4) b = ch[4-k];
      sclk_cycle(b, wr && (k == 4), wch, wdat, m);
      if (k == 5) null_bit = m;
      else if (k >= 6 && k <= 15) data = {data[8:0], m};
      else if (k >= 16 && m !== 1'b0) tail_ones++;
    end
  endtask

  initial begin
    logic [9:0] data;
    logic       nb, m;
    int         tail, c0, a0, bad;

    rst_n = 1'b0; spi_cs_n = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
    axiiv = 1'b0; axiic = '0; axiid = '0;
    repeat (5) @(negedge clk);
    chk("rst_miso", spi_miso, 1'b0);
    chk("rst_oe", spi_miso_oe, 1'b0);
    chk("rst_conv_valid", conv_valid, 1'b0);
    chk("rst_conv_channel", conv_channel, 3'd0);
    chk("rst_conv_single", conv_single, 1'b0);
    chk("rst_frame_abort", frame_abort, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // basic frame, ch3, single-ended
    tbl_write(3'd3, 10'h2A5);
    c0 = conv_pulses; a0 = abort_pulses;
    cs_low();
    chk("t1_oe_selected", spi_miso_oe, 1'b1);
    run_frame(0, 16, 1'b1, 3'd3, 1'b0, 3'd0, 10'h0, data, nb, tail);
    chk("t1_null_bit", nb, 1'b0);
    chk("t1_data", data, 10'h2A5);
    chk("t1_conv_pulses", conv_pulses - c0, 1);
    chk("t1_conv_channel", conv_channel, 3'd3);
    chk("t1_conv_single", conv_single, 1'b1);
    chk("t1_busy_in_frame", busy, 1'b1);
    cs_high();
    chk("t1_busy_after", busy, 1'b0);
    chk("t1_oe_after", spi_miso_oe, 1'b0);
    chk("t1_miso_after", spi_miso, 1'b0);
    chk("t1_no_abort", abort_pulses - a0, 0);

    // leading zeros, ch7, differential
    tbl_write(3'd7, 10'h3FF);
    c0 = conv_pulses;
    cs_low();
    run_frame(3, 16, 1'b0, 3'd7, 1'b0, 3'd0, 10'h0, data, nb, tail);
    chk("t2_data", data, 10'h3FF);
    chk("t2_null_bit", nb, 1'b0);
    chk("t2_conv_pulses", conv_pulses - c0, 1);
    chk("t2_conv_channel", conv_channel, 3'd7);
    chk("t2_conv_single", conv_single, 1'b0);
    cs_high();

    // write to the addressed channel on the snapshot cycle
    tbl_write(3'd5, 10'h155);
    cs_low();
    run_frame(0, 16, 1'b1, 3'd5, 1'b1, 3'd5, 10'h001, data, nb, tail);
    chk("t3_snapshot_old", data, 10'h155);
    cs_high();
    cs_low();
    run_frame(0, 16, 1'b1, 3'd5, 1'b0, 3'd0, 10'h0, data, nb, tail);
    chk("t3_next_new", data, 10'h001);
    chk("t3_conv_channel", conv_channel, 3'd5);
    cs_high();

    // abort after 6 data bits
    a0 = abort_pulses;
    cs_low();
    run_frame(0, 12, 1'b1, 3'd3, 1'b0, 3'd0, 10'h0, data, nb, tail);
    chk("t4_partial_bits", data[5:0], 6'b101010);
    chk("t4_busy_before", busy, 1'b1);
    cs_high();
    chk("t4_abort_pulses", abort_pulses - a0, 1);
    chk("t4_busy_after", busy, 1'b0);
    chk("t4_miso_after", spi_miso, 1'b0);
    cs_low();
    run_frame(0, 16, 1'b1, 3'd3, 1'b0, 3'd0, 10'h0, data, nb, tail);
    chk("t4_recover_data", data, 10'h2A5);
    cs_high();
    chk("t4_no_extra_abort", abort_pulses - a0, 1);

    // 20 SCLKs, tail stays at 0
    c0 = conv_pulses;
    cs_low();
    run_frame(0, 20, 1'b1, 3'd7, 1'b0, 3'd0, 10'h0, data, nb, tail);
    chk("t6_data", data, 10'h3FF);
    chk("t6_tail_ones", tail, 0);
    chk("t6_conv_pulses", conv_pulses - c0, 1);
    cs_high();

    // reset mid-DATA, released with cs_n low
    c0 = conv_pulses; a0 = abort_pulses;
    cs_low();
    run_frame(0, 10, 1'b1, 3'd7, 1'b0, 3'd0, 10'h0, data, nb, tail);
    chk("t5_mid_data_bit", data[3:0], 4'hF);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_rst_miso", spi_miso, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      sclk_cycle(1'b1, 1'b0, 3'd0, 10'h0, m);
      if (m !== 1'b0 || spi_miso_oe !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("t5_ignored_frame", bad, 0);
    chk("t5_conv_channel", conv_channel, 3'd0);
    chk("t5_conv_pulses", conv_pulses - c0, 1);
    chk("t5_no_abort", abort_pulses - a0, 0);
    cs_high();
    c0 = conv_pulses;
    cs_low();
    run_frame(0, 16, 1'b1, 3'd3, 1'b0, 3'd0, 10'h0, data, nb, tail);
    chk("t5_cleared_data", data, 10'h000);
    chk("t5_after_conv", conv_pulses - c0, 1);
    cs_high();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
